ita_hwpe_job_sequencer: RTL and testbench
=========================================

// Module: ita_hwpe_job_sequencer
// PURPOSE
//  Sits directly downstream of the ITA HWPE register file and directly upstream of the
//  four HCI streamers (input/weight/bias/output) and the ITA engine.
//  On a job trigger it latches the stream-control and tile fields, then issues
//  per-tile streamer/engine start pulses and collects streamer done flags.
//  It handles weight preload/nextload sequencing and emits one completion event per job.
// PARAMETERS
//  TILE_FIELD_W  4   width of each tile field (tile_s, tile_e, tile_p)
//  TILE_CNT_W    12  width of the tile counter; must be >= 3*TILE_FIELD_W
// PORTS
//  clk_i             in   1   clock
//  rst_ni            in   1   async active-low reset
//  clear_i           in   1   sync soft clear; returns the block to IDLE
//  start_i           in   1   job trigger pulse from the register file
//  reg_tiles_i       in   16  tile_s[3:0], tile_e[7:4], tile_p[11:8]; [15:12] unused
//  reg_ctrl_stream_i in   5   [0] weight_preload, [1] weight_nextload, [2] bias_disable, [3] bias_direction (unused here), [4] output_disable
//  input_done_i      in   1   input streamer done pulse
//  weight_done_i     in   1   weight streamer done pulse
//  bias_done_i       in   1   bias streamer done pulse
//  output_done_i     in   1   output sink done pulse
//  input_req_o       out  1   input streamer start pulse
//  weight_req_o      out  1   weight streamer start pulse
//  bias_req_o        out  1   bias streamer start pulse
//  output_req_o      out  1   output sink start pulse
//  engine_start_o    out  1   ITA engine start pulse, one per tile
//  busy_o            out  1   high in every state except IDLE
//  evt_done_o        out  1   one-cycle job completion event
//  tile_cnt_o        out  TILE_CNT_W  index of the current tile
//  state_o           out  3   state encoding: IDLE=0, ISSUE=1, WAIT=2, NL_ISSUE=3, NL_WAIT=4, DONE=5
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, latched regs 0, sticky done bits 0.
//  IDLE -> ISSUE on start_i (one cycle later).
//   - Same edge latches ctrl_stream.
//   - Same edge latches total = max(1,ts)*max(1,te)*max(1,tp); a zero field counts as 1.
//   - tile_cnt is cleared to 0.
//  start_i is ignored in every state except IDLE.
//  ISSUE (1 cycle) -> WAIT.
//   - Pulses input_req_o and engine_start_o.
//   - Pulses weight_req_o unless (weight_preload && tile_cnt==0).
//   - Pulses bias_req_o unless bias_disable.
//   - Pulses output_req_o unless output_disable.
//   - Clears the sticky done bits. A streamer that is not requested is marked done on entry.
//  WAIT: each *_done_i sets its sticky bit.
//   - Done flags arriving in the ISSUE cycle are ignored.
//   - The cycle all four sticky bits are set (flags of that cycle included):
//     - if tile_cnt != total-1: tile_cnt++, go to ISSUE. One bubble; next req pulse 1 cycle later.
//     - else if weight_nextload: go to NL_ISSUE.
//     - else: go to DONE.
//  NL_ISSUE (1 cycle): pulses weight_req_o only, then goes to NL_WAIT.
//  NL_WAIT: waits for weight_done_i, then goes to DONE.
//  DONE (1 cycle): evt_done_o=1, then goes to IDLE. tile_cnt_o holds its final value until the next start_i.
//  All *_o pulses are registered (asserted in the state's cycle only, never combinational from inputs).
//  clear_i has priority over everything, in any state.
//   - Next cycle: IDLE, all pulses 0, sticky bits 0, tile_cnt 0.
//   - No evt_done_o is issued for the aborted job.
//  Async reset mid-job: immediate return to reset values; no pending pulse survives.
//  Multiplication is unsigned. Max total is 15*15*15=3375, which fits in 12 bits; no wrap.
// TESTING
//  1. tiles=0x000, ctrl=0 -> one ISSUE; all 4 reqs + engine_start at start+1; evt_done 1 cycle after last done.
//  2. tiles=0x222 (8 tiles), ctrl=0, dones 3 cycles after each req -> 8 engine_start pulses; tile_cnt_o 0..7; one evt_done.
//  3. ctrl=0b00101 (preload, bias_disable), tiles=0x002 -> tile0: no weight_req/bias_req; tile1: weight_req yes, bias_req no.
//  4. ctrl=0b10010 (nextload, output_disable), tiles=0x001 -> after tile done, one extra weight_req; evt_done only after that weight_done.
//  5. Done flags in mixed order, incl. all four in the same cycle, and a done pulse in the ISSUE cycle -> ISSUE-cycle flag ignored; progression matches rules.
//  6. clear_i in WAIT at tile 3, start_i pulsed while busy, rst_ni low mid-NL_WAIT -> IDLE next cycle / ignored / immediate reset; no evt_done.

Source files
------------

// File: rtl/ita_hwpe_job_sequencer.sv
// Job sequencer: latches tiles/stream ctrl on start, pulses per-tile streamer/engine starts, one done event per job.
// Pulses are registered (1 cycle after the deciding edge); no backpressure, progress is gated by the streamer done pulses.
module ita_hwpe_job_sequencer #(
    parameter int unsigned TILE_FIELD_W = 4,
    parameter int unsigned TILE_CNT_W   = 12
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  clear_i,
    input  logic                  start_i,
    input  logic [15:0]           reg_tiles_i,
    input  logic [4:0]            reg_ctrl_stream_i,
    input  logic                  input_done_i,
    input  logic                  weight_done_i,
    input  logic                  bias_done_i,
    input  logic                  output_done_i,
    output logic                  input_req_o,
    output logic                  weight_req_o,
    output logic                  bias_req_o,
    output logic                  output_req_o,
    output logic                  engine_start_o,
    output logic                  busy_o,
    output logic                  evt_done_o,
    output logic [TILE_CNT_W-1:0] tile_cnt_o,
    output logic [2:0]            state_o
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        ISSUE    = 3'd1,
        WAIT     = 3'd2,
        NL_ISSUE = 3'd3,
        NL_WAIT  = 3'd4,
        DONE     = 3'd5
    } state_e;

    state_e                state_q, state_d;
    logic [TILE_CNT_W-1:0] tile_cnt_q, tile_cnt_d;
    logic [TILE_CNT_W-1:0] total_q, total_d;
    logic [4:0]            ctrl_q, ctrl_d;
    logic [3:0]            done_q, done_d;   // {output, bias, weight, input}
    logic [3:0]            done_all;
    logic                  last_tile;
    logic                  first_tile;
    logic                  unused_bits;

    assign unused_bits = ^{reg_tiles_i[15:3*TILE_FIELD_W], ctrl_q[3]};

    function automatic logic [TILE_CNT_W-1:0] at_least_one(input logic [TILE_FIELD_W-1:0] f);
        return (f == '0) ? TILE_CNT_W'(1) : TILE_CNT_W'(f);
    endfunction

    assign done_all   = done_q | {output_done_i, bias_done_i, weight_done_i, input_done_i};
    assign last_tile  = (tile_cnt_q == total_q - TILE_CNT_W'(1));
    assign first_tile = (tile_cnt_q == '0);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            tile_cnt_q <= '0;
            total_q    <= '0;
            ctrl_q     <= '0;
            done_q     <= '0;
        end else begin
            state_q    <= state_d;
            tile_cnt_q <= tile_cnt_d;
            total_q    <= total_d;
            ctrl_q     <= ctrl_d;
            done_q     <= done_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        tile_cnt_d = tile_cnt_q;
        total_d    = total_q;
        ctrl_d     = ctrl_q;
        done_d     = done_q;
        unique case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d    = ISSUE;
                    ctrl_d     = reg_ctrl_stream_i;
                    total_d    = at_least_one(reg_tiles_i[TILE_FIELD_W-1:0])
                               * at_least_one(reg_tiles_i[2*TILE_FIELD_W-1:TILE_FIELD_W])
                               * at_least_one(reg_tiles_i[3*TILE_FIELD_W-1:2*TILE_FIELD_W]);
                    tile_cnt_d = '0;
                end
            end
            ISSUE: begin
                // Done flags seen this cycle are dropped; unrequested streamers start out done.
                state_d = WAIT;
                done_d  = {ctrl_q[4], ctrl_q[2], ctrl_q[0] && first_tile, 1'b0};
            end
            WAIT: begin
                done_d = done_all;
                if (&done_all) begin
                    if (!last_tile) begin
                        tile_cnt_d = tile_cnt_q + TILE_CNT_W'(1);
                        state_d    = ISSUE;
                    end else if (ctrl_q[1]) begin
                        state_d = NL_ISSUE;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            NL_ISSUE: state_d = NL_WAIT;
            NL_WAIT:  if (weight_done_i) state_d = DONE;
            DONE:     state_d = IDLE;
            default:  state_d = IDLE;
        endcase
        if (clear_i) begin
            state_d    = IDLE;
            tile_cnt_d = '0;
            done_d     = '0;
        end
    end

    // All outputs decode flop state only, so every pulse lives exactly in its state's cycle.
    always_comb begin
        input_req_o    = 1'b0;
        weight_req_o   = 1'b0;
        bias_req_o     = 1'b0;
        output_req_o   = 1'b0;
        engine_start_o = 1'b0;
        evt_done_o     = 1'b0;
        unique case (state_q)
            ISSUE: begin
                input_req_o    = 1'b1;
                engine_start_o = 1'b1;
                weight_req_o   = !(ctrl_q[0] && first_tile);
                bias_req_o     = !ctrl_q[2];
                output_req_o   = !ctrl_q[4];
            end
            NL_ISSUE: weight_req_o = 1'b1;
            DONE:     evt_done_o   = 1'b1;
            default: ;
        endcase
    end

    assign busy_o     = (state_q != IDLE);
    assign tile_cnt_o = tile_cnt_q;
    assign state_o    = state_q;

endmodule

// File: tb/tb_ita_hwpe_job_sequencer.sv
// Scoreboard bench for ita_hwpe_job_sequencer: expected issue/done records queued per job, compared as the DUT emits them.
module tb_ita_hwpe_job_sequencer;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b1;
    logic        clear_i = 1'b0;
    logic        start_i = 1'b0;
    logic [15:0] reg_tiles_i = '0;
    logic [4:0]  reg_ctrl_stream_i = '0;
    logic [3:0]  done_v = '0;
    logic        input_req_o, weight_req_o, bias_req_o, output_req_o;
    logic        engine_start_o, busy_o, evt_done_o;
    logic [11:0] tile_cnt_o;
    logic [2:0]  state_o;

    always #5 clk_i = ~clk_i;

    ita_hwpe_job_sequencer #(.TILE_FIELD_W(4), .TILE_CNT_W(12)) dut (
        .clk_i            (clk_i),
        .rst_ni           (rst_ni),
        .clear_i          (clear_i),
        .start_i          (start_i),
        .reg_tiles_i      (reg_tiles_i),
        .reg_ctrl_stream_i(reg_ctrl_stream_i),
        .input_done_i     (done_v[0]),
        .weight_done_i    (done_v[1]),
        .bias_done_i      (done_v[2]),
        .output_done_i    (done_v[3]),
        .input_req_o      (input_req_o),
        .weight_req_o     (weight_req_o),
        .bias_req_o       (bias_req_o),
        .output_req_o     (output_req_o),
        .engine_start_o   (engine_start_o),
        .busy_o           (busy_o),
        .evt_done_o       (evt_done_o),
        .tile_cnt_o       (tile_cnt_o),
        .state_o          (state_o)
    );

    // gap = cycles since the job start or the most recent done pulse
    typedef struct packed {
        logic [2:0]  st;
        logic [11:0] tile;
        logic        eng, inr, wr, br, orq, evt;
        logic [7:0]  gap;
    } rec_t;

    rec_t exp_q[$];
    rec_t obs_q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   ref_cyc = 0;

    task automatic tick();
        @(negedge clk_i);
        cyc++;
    endtask

    // Reference model of one job: records in the order the DUT must emit them.
    task automatic push_job(input logic [15:0] tiles, input logic [4:0] ctrl);
        int ts, te, tp, total;
        rec_t r;
        ts = (tiles[3:0] == 4'd0) ? 1 : int'(tiles[3:0]);
        te = (tiles[7:4] == 4'd0) ? 1 : int'(tiles[7:4]);
        tp = (tiles[11:8] == 4'd0) ? 1 : int'(tiles[11:8]);
        total = ts * te * tp;
        for (int k = 0; k < total; k++) begin
            r = '0;
            r.st = 3'd1; r.tile = 12'(k); r.eng = 1'b1; r.inr = 1'b1;
            r.wr = !(ctrl[0] && k == 0); r.br = !ctrl[2]; r.orq = !ctrl[4]; r.gap = 8'd1;
            exp_q.push_back(r);
        end
        if (ctrl[1]) begin
            r = '0;
            r.st = 3'd3; r.tile = 12'(total - 1); r.wr = 1'b1; r.gap = 8'd1;
            exp_q.push_back(r);
        end
        r = '0;
        r.st = 3'd5; r.tile = 12'(total - 1); r.evt = 1'b1; r.gap = 8'd1;
        exp_q.push_back(r);
    endtask

    // Starts a job and plays the four streamers: each answers its req after its own delay.
    task automatic run_job(input logic [15:0] tiles, input logic [4:0] ctrl,
                           input int d0, input int d1, input int d2, input int d3,
                           input int budget, output bit got_evt);
        int   cd[4];
        int   dl[4];
        rec_t r;
        dl = '{d0, d1, d2, d3};
        cd = '{0, 0, 0, 0};
        got_evt = 1'b0;
        reg_tiles_i = tiles;
        reg_ctrl_stream_i = ctrl;
        start_i = 1'b1;
        ref_cyc = cyc;
        tick();
        start_i = 1'b0;
        for (int i = 0; i < budget && !got_evt; i++) begin
            if (input_req_o | weight_req_o | bias_req_o | output_req_o | engine_start_o | evt_done_o) begin
                r.st = state_o; r.tile = tile_cnt_o; r.eng = engine_start_o; r.inr = input_req_o;
                r.wr = weight_req_o; r.br = bias_req_o; r.orq = output_req_o; r.evt = evt_done_o;
                r.gap = 8'(cyc - ref_cyc);
                obs_q.push_back(r);
                if (input_req_o)  cd[0] = dl[0];
                if (weight_req_o) cd[1] = dl[1];
                if (bias_req_o)   cd[2] = dl[2];
                if (output_req_o) cd[3] = dl[3];
                got_evt = evt_done_o;
            end
            done_v = '0;
            for (int k = 0; k < 4; k++) begin
                if (cd[k] > 0) begin
                    cd[k]--;
                    if (cd[k] == 0) begin
                        done_v[k] = 1'b1;
                        ref_cyc = cyc;
                    end
                end
            end
            tick();
        end
        done_v = '0;
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        tick();
        n_cmp++;
        if ({state_o, busy_o, evt_done_o, tile_cnt_o} !== 17'd0) begin
            n_err++;
            $display("FAIL reset_state got st=%0d busy=%b evt=%b tile=%0d want all 0", state_o, busy_o, evt_done_o, tile_cnt_o);
        end
        n_cmp++;
        if ({input_req_o, weight_req_o, bias_req_o, output_req_o, engine_start_o} !== 5'd0) begin
            n_err++;
            $display("FAIL reset_pulses got %b want 00000", {input_req_o, weight_req_o, bias_req_o, output_req_o, engine_start_o});
        end
        rst_ni = 1'b1;
        tick();
    endtask

    task automatic test_single();
        bit got; rec_t e, o;
        push_job(16'h000, 5'b00000);
        run_job(16'h000, 5'b00000, 2, 2, 2, 2, 100, got);
        n_cmp++;
        if (!got) begin n_err++; $display("FAIL single_timeout got no evt_done want one"); end
        n_cmp++;
        if (obs_q.size() != exp_q.size()) begin n_err++; $display("FAIL single_count got %0d want %0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
            if (o !== e) begin n_err++; $display("FAIL single_rec got %h want %h", o, e); end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_multi();
        bit got; rec_t e, o;
        push_job(16'h222, 5'b00000);
        run_job(16'h222, 5'b00000, 3, 3, 3, 3, 300, got);
        n_cmp++;
        if (!got) begin n_err++; $display("FAIL multi_timeout got no evt_done want one"); end
        n_cmp++;
        if (obs_q.size() != exp_q.size()) begin n_err++; $display("FAIL multi_count got %0d want %0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
            if (o !== e) begin n_err++; $display("FAIL multi_rec got %h want %h", o, e); end
        end
        exp_q.delete(); obs_q.delete();
        n_cmp++;
        if ({state_o, busy_o, tile_cnt_o} !== {3'd0, 1'b0, 12'd7}) begin
            n_err++;
            $display("FAIL multi_after got st=%0d busy=%b tile=%0d want st=0 busy=0 tile=7", state_o, busy_o, tile_cnt_o);
        end
    endtask

    task automatic test_preload();
        bit got; rec_t e, o;
        push_job(16'h002, 5'b00101);
        run_job(16'h002, 5'b00101, 2, 3, 2, 4, 100, got);
        n_cmp++;
        if (!got) begin n_err++; $display("FAIL preload_timeout got no evt_done want one"); end
        n_cmp++;
        if (obs_q.size() != exp_q.size()) begin n_err++; $display("FAIL preload_count got %0d want %0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
            if (o !== e) begin n_err++; $display("FAIL preload_rec got %h want %h", o, e); end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_nextload();
        bit got; rec_t e, o;
        push_job(16'h001, 5'b10010);
        run_job(16'h001, 5'b10010, 2, 6, 3, 2, 100, got);
        n_cmp++;
        if (!got) begin n_err++; $display("FAIL nextload_timeout got no evt_done want one"); end
        n_cmp++;
        if (obs_q.size() != exp_q.size()) begin n_err++; $display("FAIL nextload_count got %0d want %0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
            if (o !== e) begin n_err++; $display("FAIL nextload_rec got %h want %h", o, e); end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_mixed_order();
        bit got; rec_t e, o;
        push_job(16'h003, 5'b00000);
        run_job(16'h003, 5'b00000, 2, 5, 3, 4, 100, got);
        n_cmp++;
        if (!got) begin n_err++; $display("FAIL mixed_timeout got no evt_done want one"); end
        n_cmp++;
        if (obs_q.size() != exp_q.size()) begin n_err++; $display("FAIL mixed_count got %0d want %0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
            if (o !== e) begin n_err++; $display("FAIL mixed_rec got %h want %h", o, e); end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    // Dones raised during ISSUE must not count; the job needs a full fresh set in WAIT.
    task automatic test_issue_cycle_done();
        reg_tiles_i = 16'h001; reg_ctrl_stream_i = 5'b00000;
        start_i = 1'b1; tick(); start_i = 1'b0;
        done_v = 4'hF; tick(); done_v = '0;
        n_cmp++;
        if (state_o !== 3'd2) begin n_err++; $display("FAIL issue_done_wait got st=%0d want 2", state_o); end
        tick();
        n_cmp++;
        if (state_o !== 3'd2 || evt_done_o !== 1'b0) begin n_err++; $display("FAIL issue_done_ignored got st=%0d evt=%b want st=2 evt=0", state_o, evt_done_o); end
        done_v = 4'b0111; tick();
        n_cmp++;
        if (state_o !== 3'd2) begin n_err++; $display("FAIL partial_done got st=%0d want 2", state_o); end
        done_v = 4'b1000; tick(); done_v = '0;
        n_cmp++;
        if (state_o !== 3'd5 || evt_done_o !== 1'b1) begin n_err++; $display("FAIL last_done got st=%0d evt=%b want st=5 evt=1", state_o, evt_done_o); end
        tick();
        n_cmp++;
        if (state_o !== 3'd0 || evt_done_o !== 1'b0) begin n_err++; $display("FAIL back_idle got st=%0d evt=%b want st=0 evt=0", state_o, evt_done_o); end
    endtask

    task automatic test_clear();
        int  w = 0;
        bit  found = 1'b0;
        int  evts = 0;
        reg_tiles_i = 16'h222; reg_ctrl_stream_i = 5'b00000;
        start_i = 1'b1; tick(); start_i = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            if (state_o == 3'd2 && tile_cnt_o == 12'd3) begin
                found = 1'b1;
            end else begin
                if (state_o == 3'd1) w = 3;
                done_v = '0;
                if (w > 0) begin w--; if (w == 0) done_v = 4'hF; end
                tick();
            end
        end
        n_cmp++;
        if (!found) begin n_err++; $display("FAIL clear_reach got st=%0d tile=%0d want st=2 tile=3", state_o, tile_cnt_o); end
        done_v = '0; clear_i = 1'b1; tick(); clear_i = 1'b0;
        n_cmp++;
        if ({state_o, busy_o, tile_cnt_o} !== 16'd0) begin
            n_err++;
            $display("FAIL clear_idle got st=%0d busy=%b tile=%0d want 0 0 0", state_o, busy_o, tile_cnt_o);
        end
        done_v = 4'hF;
        for (int i = 0; i < 6; i++) begin
            if (evt_done_o || input_req_o || state_o != 3'd0) evts++;
            tick();
            done_v = '0;
        end
        n_cmp++;
        if (evts != 0) begin n_err++; $display("FAIL clear_no_evt got %0d active cycles want 0", evts); end
    endtask

    task automatic test_start_ignored();
        reg_tiles_i = 16'h001; reg_ctrl_stream_i = 5'b00000;
        start_i = 1'b1; tick(); start_i = 1'b0;
        tick();
        reg_tiles_i = 16'h222; start_i = 1'b1; tick(); start_i = 1'b0;
        n_cmp++;
        if (state_o !== 3'd2 || input_req_o !== 1'b0) begin n_err++; $display("FAIL start_busy got st=%0d req=%b want st=2 req=0", state_o, input_req_o); end
        done_v = 4'hF; tick(); done_v = '0;
        n_cmp++;
        if (state_o !== 3'd5 || tile_cnt_o !== 12'd0) begin n_err++; $display("FAIL start_busy_total got st=%0d tile=%0d want st=5 tile=0", state_o, tile_cnt_o); end
        tick();
    endtask

    task automatic test_reset_mid_nl();
        int evts = 0;
        reg_tiles_i = 16'h001; reg_ctrl_stream_i = 5'b00010;
        start_i = 1'b1; tick(); start_i = 1'b0;
        tick();
        done_v = 4'hF; tick(); done_v = '0;
        n_cmp++;
        if (state_o !== 3'd3 || weight_req_o !== 1'b1) begin n_err++; $display("FAIL nl_issue got st=%0d wreq=%b want st=3 wreq=1", state_o, weight_req_o); end
        tick();
        n_cmp++;
        if (state_o !== 3'd4) begin n_err++; $display("FAIL nl_wait got st=%0d want 4", state_o); end
        #1 rst_ni = 1'b0;
        #1;
        n_cmp++;
        if ({state_o, busy_o, weight_req_o, evt_done_o, tile_cnt_o} !== 18'd0) begin
            n_err++;
            $display("FAIL async_reset got st=%0d busy=%b wreq=%b evt=%b tile=%0d want all 0", state_o, busy_o, weight_req_o, evt_done_o, tile_cnt_o);
        end
        tick(); rst_ni = 1'b1;
        done_v = 4'b0010;
        for (int i = 0; i < 5; i++) begin
            tick();
            done_v = '0;
            if (evt_done_o || state_o != 3'd0) evts++;
        end
        n_cmp++;
        if (evts != 0) begin n_err++; $display("FAIL reset_no_evt got %0d active cycles want 0", evts); end
    endtask

    initial begin
        #1;
        test_reset();
        test_single();
        test_multi();
        test_preload();
        test_nextload();
        test_mixed_order();
        test_issue_cycle_done();
        test_clear();
        test_start_ignored();
        test_reset_mid_nl();
        test_single();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got no completion want finish before time limit");
        $fatal(1, "watchdog");
    end

endmodule
